// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scan front end.
//   ROWS/COLS   : keypad geometry (4x4)
//   KEY_W       : width of a hex key code
//   state_t     : scan FSM states (SCAN, HOLD)
//   KEY_MAP     : 16-entry key map, entry (row*4 + col) holds the hex code
//   one_low()   : true when exactly one bit of a column vector is low
//   low_index() : index of the lowest low bit of a column vector
//   row_drive() : active-low one-hot row drive pattern for a row index
package keypad_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEY_W = 4;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Packed so it can be sliced with a computed base; entry 0 sits in the LSBs.
  //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: E 0 F D
  localparam logic [ROWS*COLS*KEY_W-1:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic one_low(input logic [COLS-1:0] v);
    logic [COLS-1:0] n;
    n = ~v;
    // Non-zero and a power of two: exactly one column pulled low.
    return (n != '0) && ((n & (n - 1'b1)) == '0);
  endfunction

  function automatic logic [1:0] low_index(input logic [COLS-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [ROWS-1:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event bus from the scanner to the digit shift register / display path.
//   key_code  : hex value of the last accepted key
//   key_valid : one-cycle strobe marking a new key_code
//   key_held  : high while the accepted key is still down
// master modport: scanner (drives); slave modport: consumer (observes).
interface keypad_scanner_if;
  import keypad_pkg::*;

  // Handshake: key_valid is a push-only strobe with no ready. key_code is
  // valid in the strobe cycle and remains stable until the next strobe or
  // reset; the consumer must take it in the cycle key_valid is high.
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_held;

  modport master (output key_code, output key_valid, output key_held);
  modport slave  (input  key_code, input  key_valid, input  key_held);

endinterface

// File: rtl/keypad_decode.sv
// Combinational (row index, column index) -> hex key code lookup.
//   row_idx : driven row, 0..3
//   col_idx : pressed column, 0..3
//   code    : hex code from KEY_MAP
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [1:0]       row_idx,
  input  logic [1:0]       col_idx,
  output logic [KEY_W-1:0] code
);

  logic [5:0] bit_base;

  always_comb begin
    bit_base = {row_idx, col_idx, 2'b00};
    code     = KEY_MAP[bit_base +: KEY_W];
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks the active-low rows, samples the debounced
// columns at the end of each row's dwell, and reports one key event per
// physical press on the key bus.
//   clk       : system clock
//   reset     : asynchronous, active-high
//   cols      : debounced column lines, active-low (0 = pressed)
//   rows      : row drive, active-low one-hot
//   key       : key event bus (key_code, key_valid, key_held), master side
//   dbg_state : current scan FSM state
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DWELL         = 2400,
  parameter int RELEASE_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COLS-1:0]      cols,
  output logic [ROWS-1:0]      rows,
  keypad_scanner_if.master     key,
  output state_t               dbg_state
);

  localparam int CW = $clog2(DWELL);
  localparam int RW = $clog2(RELEASE_SCANS + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [RW-1:0] REL_LAST   = RW'(RELEASE_SCANS - 1);

  state_t           state;
  logic [CW-1:0]    dwell_cnt;
  logic [RW-1:0]    rel_cnt;
  logic [1:0]       row_idx;
  logic [1:0]       hold_col;
  logic [KEY_W-1:0] key_code_q;
  logic             key_valid_q;
  logic             key_held_q;

  logic             sample;
  logic [1:0]       col_idx;
  logic [KEY_W-1:0] decoded;

  assign sample  = (dwell_cnt == DWELL_LAST);
  assign col_idx = low_index(cols);

  keypad_decode u_decode (
    .row_idx (row_idx),
    .col_idx (col_idx),
    .code    (decoded)
  );

  // Columns are only looked at on the last cycle of each row's dwell, so the
  // row drive has settled through the keypad before the decision is made.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SCAN;
      dwell_cnt   <= '0;
      rel_cnt     <= '0;
      row_idx     <= 2'd0;
      hold_col    <= 2'd0;
      rows        <= 4'b1110;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      dwell_cnt   <= sample ? '0 : dwell_cnt + CW'(1);

      if (sample) begin
        case (state)
          SCAN: begin
            if (one_low(cols)) begin
              // Single key: report it once, freeze the rows on this row.
              hold_col    <= col_idx;
              key_code_q  <= decoded;
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
              rel_cnt     <= '0;
              state       <= HOLD;
            end else begin
              // Idle or multi-key reject both just move on.
              row_idx <= row_idx + 2'd1;
              rows    <= row_drive(row_idx + 2'd1);
            end
          end
          HOLD: begin
            // Only the held column matters; other keys in this row are ignored.
            if (cols[hold_col]) begin
              if (rel_cnt == REL_LAST) begin
                key_held_q <= 1'b0;
                rel_cnt    <= '0;
                row_idx    <= row_idx + 2'd1;
                rows       <= row_drive(row_idx + 2'd1);
                state      <= SCAN;
              end else begin
                rel_cnt <= rel_cnt + RW'(1);
              end
            end else begin
              // Bounce or re-press of the same key: start the release count over.
              rel_cnt <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  assign key.key_code  = key_code_q;
  assign key.key_valid = key_valid_q;
  assign key.key_held  = key_held_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with DWELL=4, RELEASE_SCANS=2.
// A physical keypad model pulls a column low only while that key's row is
// driven low; a behavioural reference model predicts every output each cycle.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int DWELL         = 4;
  localparam int RELEASE_SCANS = 2;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cols;
  logic [3:0] rows;
  state_t     dbg_state;

  always #5 clk = ~clk;

  keypad_scanner_if key_bus ();

  keypad_scanner #(
    .DWELL         (DWELL),
    .RELEASE_SCANS (RELEASE_SCANS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .key       (key_bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- physical keypad ----------------
  logic [15:0] pressed = '0;   // bit r*4+c = key at (row r, col c) is down

  always_comb begin
    cols = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!rows[r] && pressed[r*4+c]) cols[c] = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  int         cyc;
  int         m_row;
  int         m_col;
  int         m_rel;
  bit         m_held;
  bit         m_valid;
  logic [3:0] m_code;
  logic [3:0] exp_q [$];

  // ---------------- scoreboard counters ----------------
  int n_vec   = 0;
  int n_err   = 0;
  int strobes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge, using the keys held before it.
  task automatic model_edge();
    int n_low;
    int c_hit;
    if (reset) begin
      cyc = 0; m_row = 0; m_col = 0; m_rel = 0;
      m_held = 0; m_valid = 0; m_code = 4'h0;
      exp_q.delete();
      return;
    end
    m_valid = 0;
    if (cyc % DWELL == DWELL - 1) begin
      if (!m_held) begin
        n_low = 0;
        c_hit = 0;
        for (int c = 0; c < 4; c++) begin
          if (pressed[m_row*4+c]) begin
            n_low++;
            c_hit = c;
          end
        end
        if (n_low == 1) begin
          m_code  = key_tab[m_row*4+c_hit];
          m_valid = 1;
          m_held  = 1;
          m_col   = c_hit;
          m_rel   = 0;
          exp_q.push_back(m_code);
        end else begin
          m_row = (m_row + 1) % 4;
        end
      end else begin
        if (pressed[m_row*4+m_col]) begin
          m_rel = 0;
        end else begin
          m_rel++;
          if (m_rel == RELEASE_SCANS) begin
            m_held = 0;
            m_rel  = 0;
            m_row  = (m_row + 1) % 4;
          end
        end
      end
    end
    cyc++;
  endtask

  function automatic logic [3:0] exp_rows(input int r);
    logic [3:0] e;
    e    = 4'b1111;
    e[r] = 1'b0;
    return e;
  endfunction

  task automatic compare();
    check("rows", rows, exp_rows(m_row));
    check("key_valid", key_bus.key_valid, m_valid);
    check("key_code", key_bus.key_code, m_code);
    check("key_held", key_bus.key_held, m_held);
    check("state_hold", dbg_state == HOLD, m_held);
    if (key_bus.key_valid === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
      else check("strobe_code", key_bus.key_code, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
    end
  endtask

  // Reset lands between edges, well away from either clock edge.
  task automatic async_reset();
    @(posedge clk);
    model_edge();
    #2 reset = 1'b1;
    #1;
    model_edge();
    check("rst_rows", rows, 4'b1110);
    check("rst_held", key_bus.key_held, 0);
    check("rst_code", key_bus.key_code, 0);
    check("rst_valid", key_bus.key_valid, 0);
    @(negedge clk);
    step(2);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    int k;
    model_edge();
    step(2);
    check("reset_rows", rows, 4'b1110);
    reset = 1'b0;

    // 1: idle sweep
    strobes = 0;
    step(20);
    check("idle_strobes", strobes, 0);
    check("idle_code", key_bus.key_code, 0);

    // 2: press '5'
    pressed[5] = 1'b1;
    strobes = 0;
    step(20);
    check("p5_strobes", strobes, 1);
    check("p5_code", key_bus.key_code, 4'h5);
    check("p5_rows", rows, 4'b1101);
    check("p5_held", key_bus.key_held, 1);

    // 3: long hold, then release
    strobes = 0;
    step(100);
    check("hold_strobes", strobes, 0);
    pressed = '0;
    step(12);
    check("rel_held", key_bus.key_held, 0);
    check("rel_strobes", strobes, 0);

    // 4: release bounce spanning exactly one sample point
    pressed[5] = 1'b1;
    step(20);
    strobes = 0;
    pressed[5] = 1'b0;
    step(DWELL);
    pressed[5] = 1'b1;
    step(3 * DWELL);
    check("bounce_held", key_bus.key_held, 1);
    check("bounce_strobes", strobes, 0);
    pressed = '0;
    step(4 * DWELL);
    check("bounce_rel_held", key_bus.key_held, 0);

    // 5: multi-key reject, then second key during hold
    pressed = 16'h0003;
    strobes = 0;
    step(40);
    check("multi_strobes", strobes, 0);
    check("multi_held", key_bus.key_held, 0);
    pressed = '0;
    step(8);
    pressed[5] = 1'b1;
    step(20);
    pressed[7] = 1'b1;
    step(40);
    check("second_key_strobes", strobes, 1);
    check("second_key_code", key_bus.key_code, 4'h5);
    pressed[7] = 1'b0;

    // 6: async reset mid-HOLD with '5' still down
    step(4);
    strobes = 0;
    async_reset();
    step(24);
    check("post_rst_strobes", strobes, 1);
    check("post_rst_code", key_bus.key_code, 4'h5);
    pressed = '0;
    step(20);

    // random presses, pairs, bounces and resets
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 15);
      pressed[k] = 1'b1;
      if (r == 0) pressed[$urandom_range(0, 15)] = 1'b1;
      step($urandom_range(4, 40));
      if (r == 1) begin
        pressed[k] = 1'b0;
        step($urandom_range(1, 6));
        pressed[k] = 1'b1;
        step($urandom_range(4, 20));
      end
      if (r == 2) async_reset();
      pressed = '0;
      step($urandom_range(0, 30));
    end

    step(20);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
